// File: rtl/fp16_result_packer_if.sv
// Handshake bundle between the FP32-to-FP16 converter and the result packer.
// The master side produces converter results and consumes packed words; the
// slave side is the packer itself.
interface fp16_result_packer_if;
   // Input side: one converter result per handshake
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_data_i;
   logic        in_mode_i;   // 1 = fp16 element in [15:0], 0 = full fp32 word
   logic        in_of_i;
   logic        in_uf_i;
   logic        in_nv_i;
   logic        in_nx_i;

   // Output side: one packed 32-bit word per handshake
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_data_o;
   logic [3:0]  out_flags_o; // {NV,OF,UF,NX}
   logic        out_half_o;  // lone fp16 element in [15:0], upper half zero

   modport master (
      output in_valid_i, in_data_i, in_mode_i,
      output in_of_i, in_uf_i, in_nv_i, in_nx_i,
      output out_ready_i,
      input  in_ready_o,
      input  out_valid_o, out_data_o, out_flags_o, out_half_o
   );

   modport slave (
      input  in_valid_i, in_data_i, in_mode_i,
      input  in_of_i, in_uf_i, in_nv_i, in_nx_i,
      input  out_ready_i,
      output in_ready_o,
      output out_valid_o, out_data_o, out_flags_o, out_half_o
   );
endinterface

// File: rtl/fp16_result_packer.sv
// Packs converter results into 32-bit words: fp32 results pass through one
// per word, fp16 results are paired low-half-first. A lone fp16 half is pushed
// out as a partial word when an fp32 result arrives behind it or on flush.
// Also keeps sticky exception flags and a count of emitted words.
module fp16_result_packer #(
   parameter int unsigned PARM_CNT_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   fp16_result_packer_if.slave   bus,
   input  logic                  flush_i,
   input  logic                  clear_i,
   output logic [3:0]            sticky_flags_o,
   output logic [PARM_CNT_W-1:0] word_cnt_o
);

   typedef enum logic {
      ST_EMPTY = 1'b0,  // no fp16 half held
      ST_HALF  = 1'b1   // hold_q / hold_flags_q carry the low half of a pair
   } state_e;

   state_e                state_q,      state_d;
   logic [15:0]           hold_q,       hold_d;
   logic [3:0]            hold_flags_q, hold_flags_d;
   logic                  flush_pend_q, flush_pend_d;
   logic                  out_valid_q,  out_valid_d;
   logic [31:0]           out_data_q,   out_data_d;
   logic [3:0]            out_flags_q,  out_flags_d;
   logic                  out_half_q,   out_half_d;
   logic [3:0]            sticky_q,     sticky_d;
   logic [PARM_CNT_W-1:0] cnt_q,        cnt_d;

   logic [3:0] in_flags;
   logic       slot_free;
   logic       in_ready;
   logic       in_acc;
   logic       out_hs;

   assign in_flags  = {bus.in_nv_i, bus.in_of_i, bus.in_uf_i, bus.in_nx_i};
   assign slot_free = !out_valid_q || bus.out_ready_i;
   assign in_acc    = bus.in_valid_i && in_ready;
   assign out_hs    = out_valid_q && bus.out_ready_i;

   // Input ready: blocked during reset, and an fp32 result must wait while a
   // half is held because the half has to leave as a partial word first.
   always_comb begin
      in_ready = 1'b0;
      if (rst_ni) begin
         in_ready = slot_free && !((state_q == ST_HALF) && !bus.in_mode_i);
      end
   end

   // Packing state machine: next state, holding register and output register.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      hold_d       = hold_q;
      hold_flags_d = hold_flags_q;
      flush_pend_d = flush_pend_q;
      out_valid_d  = out_valid_q && !bus.out_ready_i;
      out_data_d   = out_data_q;
      out_flags_d  = out_flags_q;
      out_half_d   = out_half_q;

      case (state_q)
         ST_EMPTY: begin
            // A flush with nothing held has nothing to emit.
            flush_pend_d = 1'b0;
            if (in_acc) begin
               if (!bus.in_mode_i) begin
                  out_valid_d = 1'b1;
                  out_data_d  = bus.in_data_i;
                  out_flags_d = in_flags;
                  out_half_d  = 1'b0;
               end else begin
                  hold_d       = bus.in_data_i[15:0];
                  hold_flags_d = in_flags;
                  state_d      = ST_HALF;
               end
            end
         end
         ST_HALF: begin
            if (in_acc) begin
               // Completing the pair also satisfies any flush request.
               out_valid_d  = 1'b1;
               out_data_d   = {bus.in_data_i[15:0], hold_q};
               out_flags_d  = hold_flags_q | in_flags;
               out_half_d   = 1'b0;
               flush_pend_d = 1'b0;
               state_d      = ST_EMPTY;
            end else if (slot_free &&
                         ((bus.in_valid_i && !bus.in_mode_i) || flush_i || flush_pend_q)) begin
               out_valid_d  = 1'b1;
               out_data_d   = {16'h0000, hold_q};
               out_flags_d  = hold_flags_q;
               out_half_d   = 1'b1;
               flush_pend_d = 1'b0;
               state_d      = ST_EMPTY;
            end else if (flush_i) begin
               flush_pend_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Sticky flags and word counter; a same-cycle accept or handshake wins
   // over clear so that event is never lost.
   always_comb begin
      sticky_d = (clear_i ? 4'b0000 : sticky_q) | (in_acc ? in_flags : 4'b0000);
      cnt_d    = clear_i ? '0 : cnt_q;
      if (out_hs) begin
         cnt_d = (clear_i ? '0 : cnt_q) + PARM_CNT_W'(1);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_EMPTY;
         hold_q       <= '0;
         hold_flags_q <= '0;
         flush_pend_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_flags_q  <= '0;
         out_half_q   <= 1'b0;
         sticky_q     <= '0;
         cnt_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // computed from the same pre-edge state, independent of order.
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_flags_q <= hold_flags_d;
         flush_pend_q <= flush_pend_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_flags_q  <= out_flags_d;
         out_half_q   <= out_half_d;
         sticky_q     <= sticky_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.out_flags_o = out_flags_q;
   assign bus.out_half_o  = out_half_q;
   assign sticky_flags_o  = sticky_q;
   assign word_cnt_o      = cnt_q;

endmodule

// File: tb/tb_fp16_result_packer.sv
// Self-checking bench for fp16_result_packer: directed scenarios followed by
// a randomized run checked against a word-level packing model.
module tb_fp16_result_packer;

   localparam int CNT_W = 2;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  flags;
      logic        half;
   } word_t;

   logic             clk_i;
   logic             rst_ni;
   logic             flush_i;
   logic             clear_i;
   logic [3:0]       sticky_flags_o;
   logic [CNT_W-1:0] word_cnt_o;

   int               n_checks;
   int               n_pass;
   logic [CNT_W-1:0] exp_cnt;

   fp16_result_packer_if bus ();

   fp16_result_packer #(.PARM_CNT_W(CNT_W)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .bus            (bus),
      .flush_i        (flush_i),
      .clear_i        (clear_i),
      .sticky_flags_o (sticky_flags_o),
      .word_cnt_o     (word_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic idle();
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = '0;
      bus.in_mode_i  = 1'b0;
      bus.in_of_i    = 1'b0;
      bus.in_uf_i    = 1'b0;
      bus.in_nv_i    = 1'b0;
      bus.in_nx_i    = 1'b0;
      flush_i        = 1'b0;
      clear_i        = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic mode, input logic [31:0] data, input logic [3:0] fl);
      bus.in_valid_i = 1'b1;
      bus.in_mode_i  = mode;
      bus.in_data_i  = data;
      {bus.in_nv_i, bus.in_of_i, bus.in_uf_i, bus.in_nx_i} = fl;
   endtask

   task automatic test_reset();
      idle();
      bus.out_ready_i = 1'b1;
      rst_ni = 1'b0;
      bus.in_valid_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      n_checks++; if (bus.in_ready_o !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready_o); else n_pass++;
      n_checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); else n_pass++;
      n_checks++; if ({bus.out_data_o, bus.out_flags_o, bus.out_half_o} !== 37'h0) $display("FAIL reset_out_regs: got %h/%b/%b want 0", bus.out_data_o, bus.out_flags_o, bus.out_half_o); else n_pass++;
      n_checks++; if ({sticky_flags_o, word_cnt_o} !== '0) $display("FAIL reset_sticky_cnt: got %b/%0d want 0/0", sticky_flags_o, word_cnt_o); else n_pass++;
      bus.in_valid_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready_o); else n_pass++;
      tick();
      exp_cnt = '0;
   endtask

   task automatic test_fp16_pair();
      bus.out_ready_i = 1'b1;
      send(1'b1, 32'h0000_3C00, 4'b0000);
      @(negedge clk_i);
      n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL pair_first_ready: got %b want 1", bus.in_ready_o); else n_pass++;
      tick();
      send(1'b1, 32'hFFFF_C000, 4'b0000);
      @(negedge clk_i);
      n_checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL pair_no_early_word: got %b want 0", bus.out_valid_o); else n_pass++;
      tick();
      idle();
      @(negedge clk_i);
      n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o} !== {1'b1, 32'hC000_3C00, 1'b0, 4'b0000})
         $display("FAIL pair_word: got v=%b %h half=%b fl=%b want v=1 c0003c00 half=0 fl=0000", bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o); else n_pass++;
      tick();
      exp_cnt = exp_cnt + 1'b1;
      @(negedge clk_i);
      n_checks++; if (word_cnt_o !== exp_cnt) $display("FAIL pair_cnt: got %0d want %0d", word_cnt_o, exp_cnt); else n_pass++;
      n_checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL pair_drained: got %b want 0", bus.out_valid_o); else n_pass++;
      tick();
   endtask

   task automatic test_fp32_flags();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      exp_cnt = '0;
      send(1'b0, 32'h3F80_0000, 4'b0001);
      tick();
      idle();
      @(negedge clk_i);
      n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.out_flags_o, bus.out_half_o} !== {1'b1, 32'h3F80_0000, 4'b0001, 1'b0})
         $display("FAIL fp32_word: got v=%b %h fl=%b half=%b want v=1 3f800000 fl=0001 half=0", bus.out_valid_o, bus.out_data_o, bus.out_flags_o, bus.out_half_o); else n_pass++;
      n_checks++; if (sticky_flags_o !== 4'b0001) $display("FAIL fp32_sticky: got %b want 0001", sticky_flags_o); else n_pass++;
      tick();
      exp_cnt = exp_cnt + 1'b1;
      @(negedge clk_i);
      n_checks++; if (word_cnt_o !== exp_cnt) $display("FAIL fp32_cnt: got %0d want %0d", word_cnt_o, exp_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_mixed();
      bus.out_ready_i = 1'b1;
      send(1'b1, 32'h0000_7C00, 4'b0100);
      tick();
      send(1'b0, 32'h4049_0FDB, 4'b0000);
      @(negedge clk_i);
      n_checks++; if (bus.in_ready_o !== 1'b0) $display("FAIL mixed_blocked: got %b want 0", bus.in_ready_o); else n_pass++;
      tick();
      @(negedge clk_i);
      n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o} !== {1'b1, 32'h0000_7C00, 1'b1, 4'b0100})
         $display("FAIL mixed_partial: got v=%b %h half=%b fl=%b want v=1 00007c00 half=1 fl=0100", bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o); else n_pass++;
      n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL mixed_unblocked: got %b want 1", bus.in_ready_o); else n_pass++;
      tick();
      idle();
      @(negedge clk_i);
      n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o} !== {1'b1, 32'h4049_0FDB, 1'b0, 4'b0000})
         $display("FAIL mixed_fp32: got v=%b %h half=%b fl=%b want v=1 40490fdb half=0 fl=0000", bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o); else n_pass++;
      n_checks++; if (sticky_flags_o !== 4'b0101) $display("FAIL mixed_sticky: got %b want 0101", sticky_flags_o); else n_pass++;
      tick();
      exp_cnt = exp_cnt + 2'd2;
      @(negedge clk_i);
      n_checks++; if (word_cnt_o !== exp_cnt) $display("FAIL mixed_cnt: got %0d want %0d", word_cnt_o, exp_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_flush_stall();
      bus.out_ready_i = 1'b0;
      send(1'b1, 32'h0000_5555, 4'b0010);
      tick();
      idle();
      flush_i = 1'b1;
      @(negedge clk_i);
      n_checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL flush_pre: got %b want 0", bus.out_valid_o); else n_pass++;
      tick();
      flush_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o} !== {1'b1, 32'h0000_5555, 1'b1, 4'b0010})
            $display("FAIL flush_partial_held: cycle %0d got v=%b %h half=%b fl=%b want v=1 00005555 half=1 fl=0010", k, bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o); else n_pass++;
         tick();
      end
      bus.out_ready_i = 1'b1;
      tick();
      exp_cnt = exp_cnt + 1'b1;
      @(negedge clk_i);
      n_checks++; if ({bus.out_valid_o, word_cnt_o} !== {1'b0, exp_cnt}) $display("FAIL flush_delivered: got v=%b cnt=%0d want v=0 cnt=%0d", bus.out_valid_o, word_cnt_o, exp_cnt); else n_pass++;
      flush_i = 1'b0;
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      @(negedge clk_i);
      n_checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL flush_empty_noop: got %b want 0", bus.out_valid_o); else n_pass++;
      tick();
   endtask

   task automatic test_flush_pair_priority();
      bus.out_ready_i = 1'b1;
      send(1'b1, 32'h0000_1111, 4'b0000);
      tick();
      send(1'b1, 32'h0000_2222, 4'b1000);
      flush_i = 1'b1;
      tick();
      idle();
      @(negedge clk_i);
      n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o} !== {1'b1, 32'h2222_1111, 1'b0, 4'b1000})
         $display("FAIL prio_pair: got v=%b %h half=%b fl=%b want v=1 22221111 half=0 fl=1000", bus.out_valid_o, bus.out_data_o, bus.out_half_o, bus.out_flags_o); else n_pass++;
      tick();
      exp_cnt = exp_cnt + 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         n_checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL prio_no_partial: cycle %0d got %b want 0", k, bus.out_valid_o); else n_pass++;
         tick();
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready_i = 1'b0;
      send(1'b0, 32'hA5A5_0001, 4'b0000);
      tick();
      send(1'b0, 32'hA5A5_0002, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.in_ready_o} !== {1'b1, 32'hA5A5_0001, 1'b0})
            $display("FAIL bp_hold: cycle %0d got v=%b %h rdy=%b want v=1 a5a50001 rdy=0", k, bus.out_valid_o, bus.out_data_o, bus.in_ready_o); else n_pass++;
         tick();
      end
      bus.out_ready_i = 1'b1;
      @(negedge clk_i);
      n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready_o); else n_pass++;
      tick();
      idle();
      @(negedge clk_i);
      n_checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, 32'hA5A5_0002}) $display("FAIL bp_second: got v=%b %h want v=1 a5a50002", bus.out_valid_o, bus.out_data_o); else n_pass++;
      tick();
      exp_cnt = exp_cnt + 2'd2;
      @(negedge clk_i);
      n_checks++; if (word_cnt_o !== exp_cnt) $display("FAIL bp_cnt: got %0d want %0d", word_cnt_o, exp_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] prev;
      bus.out_ready_i = 1'b1;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      prev = '0;
      for (int i = 0; i < 5; i++) begin
         send(1'b0, 32'h1000_0000 + 32'(i), 4'b0000);
         @(negedge clk_i);
         n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL b2b_ready: word %0d got %b want 1", i, bus.in_ready_o); else n_pass++;
         if (i > 0) begin
            n_checks++; if ({bus.out_valid_o, bus.out_data_o} !== {1'b1, prev}) $display("FAIL b2b_stream: word %0d got v=%b %h want v=1 %h", i, bus.out_valid_o, bus.out_data_o, prev); else n_pass++;
         end
         prev = 32'h1000_0000 + 32'(i);
         tick();
      end
      idle();
      tick();
      @(negedge clk_i);
      n_checks++; if (word_cnt_o !== 2'd1) $display("FAIL b2b_cnt_wrap: got %0d want 1", word_cnt_o); else n_pass++;
      exp_cnt = 2'd1;
      tick();
   endtask

   task automatic test_clear();
      bus.out_ready_i = 1'b1;
      send(1'b0, 32'h7FC0_0000, 4'b1000);
      clear_i = 1'b1;
      tick();
      idle();
      exp_cnt = '0;
      @(negedge clk_i);
      n_checks++; if (sticky_flags_o !== 4'b1000) $display("FAIL clear_sticky_survives: got %b want 1000", sticky_flags_o); else n_pass++;
      n_checks++; if (word_cnt_o !== exp_cnt) $display("FAIL clear_cnt: got %0d want %0d", word_cnt_o, exp_cnt); else n_pass++;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      exp_cnt = 2'd1;
      @(negedge clk_i);
      n_checks++; if ({word_cnt_o, sticky_flags_o} !== {exp_cnt, 4'b0000}) $display("FAIL clear_with_hs: got cnt=%0d st=%b want cnt=%0d st=0000", word_cnt_o, sticky_flags_o, exp_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_pair();
      bus.out_ready_i = 1'b1;
      send(1'b1, 32'h0000_ABCD, 4'b0010);
      tick();
      idle();
      #2;
      rst_ni = 1'b0;
      #1;
      n_checks++; if ({bus.out_valid_o, bus.in_ready_o, word_cnt_o} !== {1'b0, 1'b0, 2'd0}) $display("FAIL rst_async: got v=%b rdy=%b cnt=%0d want 0/0/0", bus.out_valid_o, bus.in_ready_o, word_cnt_o); else n_pass++;
      tick();
      rst_ni = 1'b1;
      exp_cnt = '0;
      flush_i = 1'b1;
      @(negedge clk_i);
      n_checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready_o); else n_pass++;
      tick();
      flush_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         n_checks++; if ({bus.out_valid_o, sticky_flags_o} !== 5'b0) $display("FAIL rst_half_discarded: cycle %0d got v=%b st=%b want 0/0000", k, bus.out_valid_o, sticky_flags_o); else n_pass++;
         tick();
      end
   endtask

   task automatic test_random();
      word_t       exp_q[$];
      word_t       w;
      word_t       got;
      logic        pend;
      logic [15:0] pend_d;
      logic [3:0]  pend_f;
      logic [3:0]  sticky_m;
      logic        have;
      logic        it_m;
      logic [31:0] it_d;
      logic [3:0]  it_f;
      logic        stall;
      logic [37:0] prev;
      pend = 1'b0; pend_d = '0; pend_f = '0; sticky_m = '0;
      have = 1'b0; it_m = 1'b0; it_d = '0; it_f = '0;
      stall = 1'b0; prev = '0;
      for (int c = 0; c < 3200; c++) begin
         flush_i = 1'b0;
         if (!have && c < 3000 && $urandom_range(0, 3) != 0) begin
            it_m = 1'($urandom_range(0, 1));
            it_d = $urandom;
            it_f = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            have = 1'b1;
         end
         if (c >= 3050 && pend && !have) flush_i = 1'b1;
         bus.in_valid_i  = have;
         bus.in_mode_i   = it_m;
         bus.in_data_i   = it_d;
         {bus.in_nv_i, bus.in_of_i, bus.in_uf_i, bus.in_nx_i} = it_f;
         bus.out_ready_i = (c >= 3000) || ($urandom_range(0, 3) != 0);
         @(negedge clk_i);
         if (stall) begin
            n_checks++; if ({bus.out_valid_o, bus.out_data_o, bus.out_flags_o, bus.out_half_o} !== prev)
               $display("FAIL rnd_stall_stable: cycle %0d got %h want %h", c, {bus.out_valid_o, bus.out_data_o, bus.out_flags_o, bus.out_half_o}, prev); else n_pass++;
         end
         n_checks++; if ({sticky_flags_o, word_cnt_o} !== {sticky_m, exp_cnt})
            $display("FAIL rnd_sticky_cnt: cycle %0d got st=%b cnt=%0d want st=%b cnt=%0d", c, sticky_flags_o, word_cnt_o, sticky_m, exp_cnt); else n_pass++;
         if (bus.in_valid_i && bus.in_ready_o) begin
            sticky_m = sticky_m | it_f;
            have = 1'b0;
            if (!it_m) begin
               if (pend) begin
                  exp_q.push_back('{data: {16'h0000, pend_d}, flags: pend_f, half: 1'b1});
                  pend = 1'b0;
               end
               exp_q.push_back('{data: it_d, flags: it_f, half: 1'b0});
            end else if (pend) begin
               exp_q.push_back('{data: {it_d[15:0], pend_d}, flags: it_f | pend_f, half: 1'b0});
               pend = 1'b0;
            end else begin
               pend = 1'b1; pend_d = it_d[15:0]; pend_f = it_f;
            end
         end
         if (flush_i && pend) begin
            exp_q.push_back('{data: {16'h0000, pend_d}, flags: pend_f, half: 1'b1});
            pend = 1'b0;
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            got = '{data: bus.out_data_o, flags: bus.out_flags_o, half: bus.out_half_o};
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL rnd_unexpected_word: cycle %0d got %h fl=%b half=%b", c, got.data, got.flags, got.half);
            end else begin
               w = exp_q.pop_front();
               if (got !== w) $display("FAIL rnd_word: cycle %0d got %h fl=%b half=%b want %h fl=%b half=%b", c, got.data, got.flags, got.half, w.data, w.flags, w.half);
               else n_pass++;
            end
            exp_cnt = exp_cnt + 1'b1;
         end
         stall = bus.out_valid_o && !bus.out_ready_i;
         prev  = {bus.out_valid_o, bus.out_data_o, bus.out_flags_o, bus.out_half_o};
         tick();
      end
      flush_i = 1'b0;
      n_checks++; if ({have, pend, 32'(exp_q.size())} !== 34'h0) $display("FAIL rnd_drain: got pending_in=%b held=%b words_left=%0d want 0/0/0", have, pend, exp_q.size()); else n_pass++;
      idle();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      exp_cnt  = '0;
      bus.out_ready_i = 1'b1;
      idle();
      test_reset();
      test_fp16_pair();
      test_fp32_flags();
      test_mixed();
      test_flush_stall();
      test_flush_pair_priority();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_reset_mid_pair();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fp16_result_packer.md
FP16_RESULT_PACKER -- requirements
Module: fp16_result_packer

Interface
REQ-001 SHALL have parameter PARM_CNT_W, default 16, width of the emitted-word counter.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid_i  input  1  result from the FP32-to-FP16 stage is valid.
REQ-005 SHALL have port in_ready_o  output  1  packer accepts the input this cycle.
REQ-006 SHALL have port in_data_i  input  32  converter result; in fp16 mode only bits [15:0] are used.
REQ-007 SHALL have port in_mode_i  input  1  1 = fp16 element, 0 = fp32 word; same meaning as the converter's mode.
REQ-008 SHALL have ports in_of_i, in_uf_i, in_nv_i, in_nx_i  input  1 each  per-element exception flags.
REQ-009 SHALL have port flush_i  input  1  pulse; emit any held lone fp16 half.
REQ-010 SHALL have port clear_i  input  1  synchronous clear of sticky flags and counter.
REQ-011 SHALL have port out_valid_o  output  1  packed word is valid.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts the word.
REQ-013 SHALL have port out_data_o  output  32  packed word.
REQ-014 SHALL have port out_flags_o  output  4  {NV,OF,UF,NX}, OR of the flags of the word's elements.
REQ-015 SHALL have port out_half_o  output  1  word holds a single fp16 element in [15:0], [31:16]=0.
REQ-016 SHALL have port sticky_flags_o  output  4  {NV,OF,UF,NX}, accumulated since the last clear.
REQ-017 SHALL have port word_cnt_o  output  PARM_CNT_W  count of output handshakes.

Function
REQ-018 SHALL use an in-handshake on in_valid_i&&in_ready_o and an out-handshake on out_valid_o&&out_ready_i.
REQ-019 SHALL hold out_data_o, out_flags_o and out_half_o stable while out_valid_o=1 and out_ready_i=0.
REQ-020 SHALL define slot_free = !out_valid_o || out_ready_i.
REQ-021 SHALL use states EMPTY (no held half) and HALF (hold_q[15:0] and hold flags valid).
REQ-022 SHALL drive in_ready_o = slot_free, except in HALF with in_mode_i=0, where in_ready_o=0.
REQ-023 EMPTY, accept with mode=0: SHALL register out_data=in_data_i, flags=input flags, half=0, out_valid=1 next cycle, and stay in EMPTY.
REQ-024 EMPTY, accept with mode=1: SHALL set hold_q=in_data_i[15:0] and hold flags, go to HALF, and emit no word.
REQ-025 HALF, accept with mode=1: SHALL register out_data={in_data_i[15:0],hold_q}, flags=hold OR input, half=0, and go to EMPTY; latency is 1 cycle from the second accept.
REQ-026 HALF with (in_valid_i && in_mode_i=0) or flush pending, and slot_free: SHALL emit {16'h0,hold_q} with the hold flags and half=1, then go to EMPTY.
REQ-027 In HALF, a completing mode=1 accept in the same cycle as a flush SHALL take priority; the pair is emitted, and the flush is consumed with no partial word.
REQ-028 flush_i in HALF SHALL set flush_pend_q; the pending flush SHALL persist until the partial word or a pair completion is emitted.
REQ-029 flush_i in EMPTY SHALL be a no-op.
REQ-030 sticky_flags SHALL update as (clear_i ? 0 : sticky) | flags of the input accepted this cycle; a same-cycle accept therefore survives a clear.
REQ-031 word_cnt SHALL increment on each out-handshake, wrap modulo 2^PARM_CNT_W, and clear_i SHALL zero it; increment wins on the same cycle, giving 1.
REQ-032 Throughput: one fp32 word per cycle, or two fp16 elements per output word, with no bubbles while out_ready_i=1.

Reset
REQ-033 On rst_ni=0 the block SHALL immediately set state=EMPTY, flush_pend_q=0, hold_q=0, out_valid_o=0, out_data_o=0, out_flags_o=0, out_half_o=0, sticky_flags_o=0 and word_cnt_o=0.
REQ-034 With rst_ni=0, in_ready_o SHALL be 0.
REQ-035 Reset asserted mid-pair SHALL discard the held half, with no partial word emitted after release.
REQ-036 in_ready_o SHALL be 1 in the first cycle after release.

Verification
REQ-037 Two fp16 accepts, 0x3C00 then 0xC000, with out_ready_i=1 -> one word 0xC0003C00, half=0, word_cnt_o=1.
REQ-038 fp32 0x3F800000 with in_nx_i=1 -> out_data_o=0x3F800000, out_flags_o=4'b0001, sticky_flags_o=4'b0001.
REQ-039 fp16 0x7C00 (of=1), then fp32 accept -> in_ready_o=0 for 1 cycle; word 0x00007C00 with half=1 and flags 4'b0100, then the fp32 word follows.
REQ-040 fp16 held, flush_i while out_ready_i=0 and the output is full -> pending flush held; partial word emitted after out_ready_i=1.
REQ-041 Output held 5 cycles with out_ready_i=0 -> data stable, in_ready_o=0, no input lost; with PARM_CNT_W=2, 5 emitted words give word_cnt_o=1.
REQ-042 clear_i in the same cycle as an accept with nv=1 -> sticky_flags_o=4'b1000.
